// File: rtl/bus_copy_master.sv
// Word-by-word block copier: read one word, write it back out on the same bus.
// Strictly one outstanding transaction; abort is honoured only between words.
module bus_copy_master #(
   parameter int unsigned LenW = 16
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic            abort_i,
   input  logic [31:0]     src_addr_i,
   input  logic [31:0]     dst_addr_i,
   input  logic [LenW-1:0] len_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [LenW-1:0] words_done_o,
   output logic            req_o,
   output logic            we_o,
   output logic [3:0]      be_o,
   output logic [31:0]     addr_o,
   output logic [31:0]     data_o,
   input  logic            gnt_i,
   input  logic            rvalid_i,
   input  logic [31:0]     data_i
);

   localparam int unsigned AddrW = 32;
   localparam int unsigned DataW = 32;
   localparam logic [AddrW-1:0] AddrMask = 32'hFFFF_FFFC;
   localparam logic [AddrW-1:0] WordStep = AddrW'(4);

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_WAIT,
      WR_REQ,
      WR_WAIT
   } state_e;

   state_e            state_q, state_d;
   logic [AddrW-1:0]  src_q, src_d;
   logic [AddrW-1:0]  dst_q, dst_d;
   logic [LenW-1:0]   rem_q, rem_d;
   logic [LenW-1:0]   words_q, words_d;
   logic [DataW-1:0]  wdata_q, wdata_d;
   logic [AddrW-1:0]  addr_q, addr_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              req_q, req_d;
   logic              we_q, we_d;

   // State and all bus-facing outputs are registered from the next-state values
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         rem_q   <= '0;
         words_q <= '0;
         wdata_q <= '0;
         addr_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         rem_q   <= rem_d;
         words_q <= words_d;
         wdata_q <= wdata_d;
         addr_q  <= addr_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         req_q   <= req_d;
         we_q    <= we_d;
      end
   end

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      rem_d   = rem_q;
      words_d = words_q;
      wdata_d = wdata_q;
      done_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               words_d = '0;
               if (len_i != '0) begin
                  src_d   = src_addr_i & AddrMask;
                  dst_d   = dst_addr_i & AddrMask;
                  rem_d   = len_i;
                  state_d = RD_REQ;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         RD_REQ: begin
            if (gnt_i) state_d = RD_WAIT;
         end
         RD_WAIT: begin
            if (rvalid_i) begin
               wdata_d = data_i;
               state_d = WR_REQ;
            end
         end
         WR_REQ: begin
            if (gnt_i) state_d = WR_WAIT;
         end
         WR_WAIT: begin
            // Word boundary: the only place abort is looked at
            if (rvalid_i) begin
               words_d = words_q + LenW'(1);
               src_d   = src_q + WordStep;
               dst_d   = dst_q + WordStep;
               rem_d   = rem_q - LenW'(1);
               if ((rem_q == LenW'(1)) || abort_i) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = RD_REQ;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Request outputs follow the state being entered; address holds otherwise
   always_comb begin
      busy_d = (state_d != IDLE);
      req_d  = (state_d == RD_REQ) || (state_d == WR_REQ);
      we_d   = (state_d == WR_REQ);
      addr_d = addr_q;
      if (state_d == RD_REQ) begin
         addr_d = src_d;
      end else if (state_d == WR_REQ) begin
         addr_d = dst_d;
      end
   end

   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign words_done_o = words_q;
   assign req_o        = req_q;
   assign we_o         = we_q;
   assign be_o         = 4'hF;
   assign addr_o       = addr_q;
   assign data_o       = wdata_q;

endmodule

// File: tb/tb_bus_copy_master.sv
// Bench for bus_copy_master: table of copy scenarios against a req/gnt/rvalid
// responder model, with a scoreboard of expected bus transactions.
module tb_bus_copy_master;

   localparam int unsigned LenW = 16;

   logic            clk_i = 1'b0;
   logic            rst_i = 1'b1;
   logic            start_i = 1'b0;
   logic            abort_i = 1'b0;
   logic [31:0]     src_addr_i = '0;
   logic [31:0]     dst_addr_i = '0;
   logic [LenW-1:0] len_i = '0;
   logic            busy_o, done_o, req_o, we_o;
   logic [LenW-1:0] words_done_o;
   logic [3:0]      be_o;
   logic [31:0]     addr_o, data_o;
   logic            gnt_i = 1'b0;
   logic            rvalid_i = 1'b0;
   logic [31:0]     data_i = '0;

   bus_copy_master #(.LenW(LenW)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
      .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_i(len_i),
      .busy_o(busy_o), .done_o(done_o), .words_done_o(words_done_o),
      .req_o(req_o), .we_o(we_o), .be_o(be_o), .addr_o(addr_o), .data_o(data_o),
      .gnt_i(gnt_i), .rvalid_i(rvalid_i), .data_i(data_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
   } txn_t;

   typedef struct {
      string       name;
      logic [31:0] src;
      logic [31:0] dst;
      int          len;
      int          gd;
      int          lat;
      bit          spur;
      bit          restart;
      int          abort_at;
      int          exp_words;
      int          exp_cyc;
   } vec_t;

   txn_t        sb[$];
   logic [31:0] mem [logic [31:0]];
   int          n_cmp = 0;
   int          n_err = 0;

   int          gnt_dly = 0;
   int          rsp_lat = 1;
   bit          spur = 1'b0;
   int          gcnt = 0, pcnt = 0;
   bit          pend = 1'b0;
   logic [31:0] pdata = '0;
   int          rd_cnt = 0, rsp_cnt = 0, stab_err = 0;
   bit          hold_v = 1'b0;
   logic [64:0] hold = '0;

   function automatic logic [31:0] rd_word(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return {~a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic serve();
      txn_t e;
      if (sb.size() == 0) begin
         check("unexpected_req", {31'b0, req_o, addr_o}, 64'h0);
      end else begin
         e = sb.pop_front();
         check("txn_we", 64'(we_o), 64'(e.we));
         check("txn_addr", 64'(addr_o), 64'(e.addr));
         check("txn_be", 64'(be_o), 64'h F);
      end
      if (we_o) begin
         if (e.we) check("txn_wdata", 64'(data_o), 64'(e.data));
         mem[addr_o] = data_o;
         pdata = 32'h0;
      end else begin
         pdata = rd_word(addr_o);
         rd_cnt++;
      end
   endtask

   // Responder: grant after gnt_dly waiting cycles, respond rsp_lat cycles after grant
   always @(negedge clk_i) begin
      gnt_i    = 1'b0;
      rvalid_i = 1'b0;
      data_i   = 32'hBAD0_BAD0;
      if (rst_i) begin
         pend   = 1'b0;
         gcnt   = 0;
         hold_v = 1'b0;
      end else if (pend) begin
         pcnt++;
         if (pcnt >= rsp_lat) begin
            rvalid_i = 1'b1;
            data_i   = pdata;
            pend     = 1'b0;
            rsp_cnt++;
         end
      end else if (req_o) begin
         if (hold_v && (hold !== {we_o, addr_o, data_o})) stab_err++;
         if (gcnt >= gnt_dly) begin
            gnt_i  = 1'b1;
            gcnt   = 0;
            hold_v = 1'b0;
            serve();
            pend = 1'b1;
            pcnt = 0;
         end else begin
            gcnt++;
            hold_v = 1'b1;
            hold   = {we_o, addr_o, data_o};
            if (spur) rvalid_i = 1'b1;
         end
      end else if (hold_v) begin
         stab_err++;
         hold_v = 1'b0;
      end
   end

   task automatic run_vec(input vec_t v);
      int          cyc;
      int          busy_err;
      int          req_seen;
      logic [31:0] a;
      logic [31:0] d;
      gnt_dly = v.gd; rsp_lat = v.lat; spur = v.spur;
      rd_cnt = 0; rsp_cnt = 0; stab_err = 0;
      for (int i = 0; i < v.exp_words; i++) begin
         a = (v.src & 32'hFFFF_FFFC) + 32'(4 * i);
         d = (v.dst & 32'hFFFF_FFFC) + 32'(4 * i);
         sb.push_back('{1'b0, a, rd_word(a)});
         sb.push_back('{1'b1, d, rd_word(a)});
      end
      src_addr_i = v.src; dst_addr_i = v.dst; len_i = LenW'(v.len); start_i = 1'b1;
      cyc = 0; busy_err = 0;
      for (int c = 1; c <= 4000; c++) begin
         @(negedge clk_i);
         start_i = v.restart && (c == 5);
         if (v.restart && c == 5) begin
            src_addr_i = 32'hDEAD_0000;
            len_i = LenW'(1);
         end
         if (v.abort_at > 0 && rd_cnt >= v.abort_at) abort_i = 1'b1;
         if (done_o) begin
            cyc = c;
            break;
         end
         if (busy_o !== (v.exp_words > 0)) busy_err++;
      end
      start_i = 1'b0;
      check({v.name, "/done_seen"}, 64'(cyc > 0), 64'h1);
      if (v.exp_cyc > 0) check({v.name, "/done_cycle"}, 64'(cyc), 64'(v.exp_cyc));
      check({v.name, "/busy_profile"}, 64'(busy_err), 64'h0);
      check({v.name, "/busy_at_done"}, 64'(busy_o), 64'h0);
      check({v.name, "/words_done"}, 64'(words_done_o), 64'(v.exp_words));
      check({v.name, "/responses"}, 64'(rsp_cnt), 64'(2 * v.exp_words));
      check({v.name, "/sb_empty"}, 64'(sb.size()), 64'h0);
      check({v.name, "/req_stable"}, 64'(stab_err), 64'h0);
      abort_i = 1'b0;
      sb.delete();
      @(negedge clk_i);
      check({v.name, "/done_pulse"}, 64'(done_o), 64'h0);
      req_seen = 0;
      repeat (4) begin
         @(negedge clk_i);
         if (req_o) req_seen++;
      end
      check({v.name, "/idle_after"}, 64'(req_seen), 64'h0);
      check({v.name, "/words_hold"}, 64'(words_done_o), 64'(v.exp_words));
   endtask

   vec_t vecs[7];
   vec_t clean;

   initial begin
      int waited;
      mem[32'h0] = 32'h02c0_05b7;
      mem[32'h4] = 32'h0005_a023;
      mem[32'h8] = 32'h0200_0537;
      vecs[0] = '{"basic",     32'h0000_0000, 32'h0000_1000, 3, 0, 1, 1'b0, 1'b0, 0, 3, 13};
      vecs[1] = '{"zero_len",  32'h0000_0100, 32'h0000_2000, 0, 0, 1, 1'b0, 1'b0, 0, 0, 1};
      vecs[2] = '{"backpress", 32'h0000_3000, 32'h0000_5000, 4, 3, 3, 1'b0, 1'b0, 0, 4, 0};
      vecs[3] = '{"abort",     32'h0000_3100, 32'h0000_6000, 8, 0, 1, 1'b0, 1'b0, 3, 3, 13};
      vecs[4] = '{"wrap_rest", 32'hFFFF_FFF8, 32'h0000_4000, 3, 0, 1, 1'b0, 1'b1, 0, 3, 13};
      vecs[5] = '{"spur_rv",   32'h0000_3203, 32'h0000_6103, 5, 2, 2, 1'b1, 1'b0, 0, 5, 0};
      vecs[6] = '{"single",    32'h0000_3400, 32'h0000_6400, 1, 0, 1, 1'b0, 1'b0, 0, 1, 5};
      clean   = '{"post_rst",  32'h0000_3500, 32'h0000_6500, 2, 0, 1, 1'b0, 1'b0, 0, 2, 9};

      repeat (2) @(negedge clk_i);
      check("rst_busy", 64'(busy_o), 64'h0);
      check("rst_done", 64'(done_o), 64'h0);
      check("rst_words", 64'(words_done_o), 64'h0);
      check("rst_req", 64'(req_o), 64'h0);
      check("rst_we", 64'(we_o), 64'h0);
      check("rst_be", 64'(be_o), 64'hF);
      check("rst_addr", 64'(addr_o), 64'h0);
      check("rst_data", 64'(data_o), 64'h0);
      rst_i = 1'b0;
      @(negedge clk_i);

      foreach (vecs[i]) run_vec(vecs[i]);

      // Reset while parked in the second word's write request
      gnt_dly = 20; rsp_lat = 1; spur = 1'b0;
      for (int i = 0; i < 2; i++) begin
         sb.push_back('{1'b0, 32'h7000 + 32'(4 * i), rd_word(32'h7000 + 32'(4 * i))});
         sb.push_back('{1'b1, 32'h8000 + 32'(4 * i), rd_word(32'h7000 + 32'(4 * i))});
      end
      src_addr_i = 32'h7000; dst_addr_i = 32'h8000; len_i = LenW'(4); start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      waited = 0;
      while (!(req_o && we_o && words_done_o == LenW'(1)) && waited < 500) begin
         @(negedge clk_i);
         waited++;
      end
      check("rst_mid/reached_wr_req", 64'(req_o && we_o), 64'h1);
      rst_i = 1'b1;
      #1;
      check("rst_mid/req", 64'(req_o), 64'h0);
      check("rst_mid/busy", 64'(busy_o), 64'h0);
      check("rst_mid/words", 64'(words_done_o), 64'h0);
      check("rst_mid/addr", 64'(addr_o), 64'h0);
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
      sb.delete();
      @(negedge clk_i);
      check("rst_mid/idle_busy", 64'(busy_o), 64'h0);
      run_vec(clean);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/bus_copy_master.md
Name: bus_copy_master

Overview:
- Bus initiator for the req/gnt/rvalid peripheral bus; it is the master-side counterpart to responders such as the boot ROM and other memory-mapped slaves.
- Copies a block of 32-bit words from a source address range to a destination address range. Each word is one read transaction followed by one write transaction.
- Used at boot to move images from ROM or flash windows into RAM without CPU involvement.
- Only one transaction is outstanding at any time.

Parameters:
LenW, 16, width of the word-count input and of the progress counter.

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous active-high reset
start_i  input  1  single-cycle start strobe; sampled only when idle
abort_i  input  1  level; stop the copy at the next word boundary
src_addr_i  input  32  source byte address; bits [1:0] ignored
dst_addr_i  input  32  destination byte address; bits [1:0] ignored
len_i  input  LenW  number of words to copy
busy_o  output  1  copy in progress
done_o  output  1  one-cycle completion pulse
words_done_o  output  LenW  words fully written in the current or last copy
req_o  output  1  bus request
we_o  output  1  1 = write, 0 = read
be_o  output  4  byte enables; always 4'hF
addr_o  output  32  bus word address; bits [1:0] always 0
data_o  output  32  write data
gnt_i  input  1  grant; a transfer is accepted in any cycle where req_o && gnt_i
rvalid_i  input  1  response valid; arrives for both reads and writes
data_i  input  32  read data, valid when rvalid_i

Behaviour:
- Reset (asynchronous, active-high):
  - FSM goes to IDLE.
  - busy_o=0, done_o=0, words_done_o=0, req_o=0, we_o=0, be_o=4'hF, addr_o=0, data_o=0.
  - Internal address, count and data registers clear to 0.
  - Reset during a copy drops req_o immediately. Any pending rvalid_i after reset is ignored.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT.
  - IDLE, start_i=1, len_i!=0: latch the source address, destination address and length; clear words_done_o; go to RD_REQ; busy_o=1 from the next cycle.
  - IDLE, start_i=1, len_i==0: no bus traffic; busy_o stays 0; done_o pulses the next cycle; words_done_o=0.
  - RD_REQ: req_o=1, we_o=0, addr_o=src. On gnt_i go to RD_WAIT.
  - RD_WAIT: req_o=0. On rvalid_i capture data_i into the write-data register and go to WR_REQ.
  - WR_REQ: req_o=1, we_o=1, addr_o=dst, data_o=captured word. On gnt_i go to WR_WAIT.
  - WR_WAIT: on rvalid_i, words_done_o+1, src+4, dst+4, remaining-1.
    - If remaining becomes 0, or abort_i is high, go to IDLE: busy_o=0 and done_o=1 in the next cycle.
    - Otherwise go to RD_REQ.
- Request stability: while req_o=1 and gnt_i=0, req_o, we_o, addr_o and data_o hold stable. There is no request withdrawal.
- Response latency: any latency of 1 or more cycles after grant is tolerated. rvalid_i in IDLE, RD_REQ or WR_REQ is ignored.
- abort_i:
  - Never cuts a read/write pair.
  - Sampled only at WR_WAIT completion.
  - Asserted in IDLE, it has no effect.
- start_i while busy is ignored.
- Address arithmetic is modulo 2^32 (0xFFFFFFFC + 4 wraps to 0x0). words_done_o counts modulo 2^LenW.
- Throughput with a same-cycle-grant, 1-cycle-rvalid responder: 4 cycles per word. With start at cycle 0:
  - first read request at cycle 1, first write request at cycle 3;
  - for N words, done_o is asserted at cycle 4N+1.

Test Plan:
- Basic copy: ROM model (same-cycle grant, 1-cycle rvalid) preloaded with 0x02c005b7, 0x0005a023, 0x02000537; start at cycle 0, src=0x0, dst=0x1000, len=3 -> reads at 0x0/0x4/0x8, writes at 0x1000/0x1004/0x1008 with matching data, be_o=4'hF; done_o at cycle 13; words_done_o=3; busy_o high for cycles 1-12.
- Zero length: start with len=0 -> no req_o at any time; done_o at cycle 1; busy_o never 1.
- Backpressure: gnt_i held low for 3 cycles on each request, rvalid delayed 2 cycles -> req_o, addr_o and data_o stable throughout; copied data correct; done_o after all 2*N responses.
- Abort: len=8, abort_i raised during the read of word 3 -> word 3 write still completes; done_o pulses; words_done_o=3; no further req_o.
- Wrap and ignore: src=0xFFFFFFF8, len=3 -> reads at 0xFFFFFFF8, 0xFFFFFFFC, 0x0. Second start_i mid-copy -> ignored. Spurious rvalid_i in RD_REQ -> no state change.
- Reset mid-op: assert rst_i while in WR_REQ -> req_o and busy_o drop the same cycle without waiting for a clock edge; words_done_o=0; a clean copy succeeds after release.
